// File: rtl/tank_pkg.sv
// Shared types and constants for the tank movement blocks: headings, FSM states,
// HID keycodes and the 640x480 playfield.
package tank_pkg;

  typedef enum logic [2:0] {
    HEAD_N  = 3'd0,
    HEAD_NE = 3'd1,
    HEAD_E  = 3'd2,
    HEAD_SE = 3'd3,
    HEAD_S  = 3'd4,
    HEAD_SW = 3'd5,
    HEAD_W  = 3'd6,
    HEAD_NW = 3'd7
  } heading_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_MOVE   = 2'd2
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // A key counts as pressed when any of the four report slots carries it.
  function automatic logic key_pressed(input logic [31:0] keycode, input logic [7:0] key);
    return (keycode[7:0] == key) | (keycode[15:8] == key) |
           (keycode[23:16] == key) | (keycode[31:24] == key);
  endfunction

endpackage

// File: rtl/tank_heading_lut.sv
// Heading to per-axis signed unit displacement; axis-aligned headings use STEP,
// diagonals use DIAG_STEP on both axes. Screen Y grows downward, so N is -Y.
module tank_heading_lut
  import tank_pkg::*;
#(
  parameter int STEP      = 3,
  parameter int DIAG_STEP = 2
) (
  input  heading_t           heading,
  output logic signed [11:0] dx,
  output logic signed [11:0] dy
);

  localparam logic signed [11:0] S = 12'(STEP);
  localparam logic signed [11:0] D = 12'(DIAG_STEP);

  // Displacement table indexed by heading.
  always_comb begin
    dx = 12'sd0;
    dy = 12'sd0;
    case (heading)
      HEAD_N:  begin dx = 12'sd0; dy = -S;     end
      HEAD_NE: begin dx = D;      dy = -D;     end
      HEAD_E:  begin dx = S;      dy = 12'sd0; end
      HEAD_SE: begin dx = D;      dy = D;      end
      HEAD_S:  begin dx = 12'sd0; dy = S;      end
      HEAD_SW: begin dx = -D;     dy = D;      end
      HEAD_W:  begin dx = -S;     dy = 12'sd0; end
      HEAD_NW: begin dx = -D;     dy = -D;     end
      default: begin dx = 12'sd0; dy = 12'sd0; end
    endcase
  end

endmodule

// File: rtl/tank_motion.sv
// Per-tank position/heading generator, updated once per video frame.
// Define TANK_DIAG_EN for 8 headings; otherwise the tank turns in 90-degree steps.
module tank_motion
  import tank_pkg::*;
#(
  parameter logic [9:0] INIT_X       = 10'd100,
  parameter logic [9:0] INIT_Y       = 10'd100,
  parameter logic [2:0] INIT_HEADING = 3'd0,
  parameter int         STEP         = 3,
  parameter int         DIAG_STEP    = 2,
  parameter int         TANK_SIZE    = 8,
  parameter int         X_MIN        = 0,
  parameter int         X_MAX        = SCREEN_W - 1,
  parameter int         Y_MIN        = 0,
  parameter int         Y_MAX        = SCREEN_H - 1,
  parameter int         ROT_COOLDOWN = 8,
  parameter logic [7:0] KEY_FWD      = 8'h1A,
  parameter logic [7:0] KEY_BACK     = 8'h16,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_RIGHT    = 8'h07
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  output logic [9:0]  TankX,
  output logic [9:0]  TankY,
  output logic [2:0]  Heading,
  output logic        moving,
  output logic        update_done
);

  localparam int CD_W = $clog2(ROT_COOLDOWN) + 1;
  localparam logic signed [11:0] SIZE12 = 12'(TANK_SIZE);
  localparam logic signed [11:0] XMIN12 = 12'(X_MIN);
  localparam logic signed [11:0] XMAX12 = 12'(X_MAX);
  localparam logic signed [11:0] YMIN12 = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX12 = 12'(Y_MAX);

`ifdef TANK_DIAG_EN
  localparam logic [2:0] ROT_STEP  = 3'd1;
  localparam heading_t   HEAD_INIT = heading_t'(INIT_HEADING);
`else
  localparam logic [2:0] ROT_STEP  = 3'd2;
  localparam heading_t   HEAD_INIT = heading_t'(INIT_HEADING & 3'b110);
`endif

  state_t            state_r;
  heading_t          heading_r;
  logic              frame_q_r;
  logic              fwd_r, back_r, left_r, right_r;
  logic [CD_W-1:0]   cooldown_r;
  logic [9:0]        tank_x_r, tank_y_r;
  logic              moving_r, done_r;

  logic              tick_s, turn_s;
  logic signed [11:0] dx_s, dy_s, delta_x_s, delta_y_s, cand_x_s, cand_y_s;
  logic              ok_x_s, ok_y_s;
  logic [9:0]        next_x_s, next_y_s;

  assign tick_s = frame_clk & ~frame_q_r;
  assign turn_s = left_r ^ right_r;

  tank_heading_lut #(
    .STEP      (STEP),
    .DIAG_STEP (DIAG_STEP)
  ) u_lut (
    .heading (heading_r),
    .dx      (dx_s),
    .dy      (dy_s)
  );

  // Candidate position for this frame; each axis is bounds-checked on its own so
  // a diagonal against a wall keeps sliding along it.
  always_comb begin
    delta_x_s = 12'sd0;
    delta_y_s = 12'sd0;
    if (fwd_r && !back_r) begin
      delta_x_s = dx_s;
      delta_y_s = dy_s;
    end else if (back_r && !fwd_r) begin
      delta_x_s = -dx_s;
      delta_y_s = -dy_s;
    end else begin
      delta_x_s = 12'sd0;
      delta_y_s = 12'sd0;
    end
    cand_x_s = $signed({2'b00, tank_x_r}) + delta_x_s;
    cand_y_s = $signed({2'b00, tank_y_r}) + delta_y_s;
    ok_x_s   = ((cand_x_s - SIZE12) >= XMIN12) && ((cand_x_s + SIZE12) <= XMAX12);
    ok_y_s   = ((cand_y_s - SIZE12) >= YMIN12) && ((cand_y_s + SIZE12) <= YMAX12);
    next_x_s = ok_x_s ? cand_x_s[9:0] : tank_x_r;
    next_y_s = ok_y_s ? cand_y_s[9:0] : tank_y_r;
  end

  // Frame FSM: latch keys on the tick, rotate, then commit the move.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_WAIT;
      heading_r  <= HEAD_INIT;
      frame_q_r  <= 1'b0;
      fwd_r      <= 1'b0;
      back_r     <= 1'b0;
      left_r     <= 1'b0;
      right_r    <= 1'b0;
      cooldown_r <= {CD_W{1'b0}};
      tank_x_r   <= INIT_X;
      tank_y_r   <= INIT_Y;
      moving_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      frame_q_r <= frame_clk;
      done_r    <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (tick_s) begin
            fwd_r   <= key_pressed(keycode, KEY_FWD);
            back_r  <= key_pressed(keycode, KEY_BACK);
            left_r  <= key_pressed(keycode, KEY_LEFT);
            right_r <= key_pressed(keycode, KEY_RIGHT);
            state_r <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          if (turn_s) begin
            if (cooldown_r == {CD_W{1'b0}}) begin
              heading_r  <= right_r ? heading_t'(heading_r + ROT_STEP)
                                    : heading_t'(heading_r - ROT_STEP);
              cooldown_r <= CD_W'(ROT_COOLDOWN - 1);
            end else begin
              cooldown_r <= cooldown_r - CD_W'(1);
            end
          end else begin
            cooldown_r <= {CD_W{1'b0}};
          end
          done_r  <= 1'b1;
          state_r <= ST_MOVE;
        end
        ST_MOVE: begin
          tank_x_r <= next_x_s;
          tank_y_r <= next_y_s;
          moving_r <= (next_x_s != tank_x_r) || (next_y_s != tank_y_r);
          state_r  <= ST_WAIT;
        end
        default: state_r <= ST_WAIT;
      endcase
    end
  end

  assign TankX       = tank_x_r;
  assign TankY       = tank_y_r;
  assign Heading     = heading_r;
  assign moving      = moving_r;
  assign update_done = done_r;

endmodule

// File: tb/tb_tank_motion.sv
// Self-checking bench for tank_motion: directed frames plus randomized traffic,
// checked every cycle against a frame-level behavioural model.
module tb_tank_motion;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [31:0] keycode;
  logic [9:0]  TankX, TankY;
  logic [2:0]  Heading;
  logic        moving, update_done;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;
  bit chk_en = 1'b0;

`ifdef TANK_DIAG_EN
  localparam int RS = 1;
`else
  localparam int RS = 2;
`endif

  always #5 Clk = ~Clk;

  tank_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .TankX       (TankX),
    .TankY       (TankY),
    .Heading     (Heading),
    .moving      (moving),
    .update_done (update_done)
  );

  // Model: visible values plus the frame result waiting to become visible.
  int m_x, m_y, m_h, m_cd, p_x, p_y, p_h, stage;
  bit m_mov, m_done, p_mov, last_fc;
  int ux[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int uy[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  function automatic bit has(input logic [31:0] kc, input logic [7:0] k);
    for (int i = 0; i < 4; i++) if (kc[i*8 +: 8] == k) return 1'b1;
    return 1'b0;
  endfunction

  initial begin : model
    bit tick, acc, l, r, f, b;
    int h, dir, st, cx, cy;
    stage = 0; m_x = 100; m_y = 100; m_h = 0; m_cd = 0;
    m_mov = 0; m_done = 0; last_fc = 0;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        m_x = 100; m_y = 100; m_h = 0; m_cd = 0;
        m_mov = 0; m_done = 0; stage = 0; last_fc = 0;
      end else begin
        tick = frame_clk && !last_fc;
        acc  = tick && (stage == 0);
        if (stage == 1) begin
          m_h = p_h; m_done = 1; stage = 2;
        end else if (stage == 2) begin
          m_x = p_x; m_y = p_y; m_mov = p_mov; m_done = 0; stage = 0;
        end else begin
          m_done = 0;
        end
        if (acc) begin
          l = has(keycode, 8'h04); r = has(keycode, 8'h07);
          f = has(keycode, 8'h1A); b = has(keycode, 8'h16);
          h = m_h;
          if (l != r) begin
            if (m_cd == 0) begin
              h = r ? (h + RS) % 8 : (h + 8 - RS) % 8;
              m_cd = 7;
            end else m_cd--;
          end else m_cd = 0;
          dir = (f && !b) ? 1 : ((b && !f) ? -1 : 0);
          st  = (h % 2 == 1) ? 2 : 3;
          cx  = m_x + dir * ux[h] * st;
          cy  = m_y + dir * uy[h] * st;
          p_x = (cx - 8 >= 0 && cx + 8 <= 639) ? cx : m_x;
          p_y = (cy - 8 >= 0 && cy + 8 <= 479) ? cy : m_y;
          p_mov = (p_x != m_x) || (p_y != m_y);
          p_h = h;
          stage = 1;
        end
        last_fc = frame_clk;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        chk("TankX", int'(TankX), m_x);
        chk("TankY", int'(TankY), m_y);
        chk("Heading", int'(Heading), m_h);
        chk("moving", int'(moving), int'(m_mov));
        chk("update_done", int'(update_done), int'(m_done));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One frame: two cycles high, two low; counts update_done pulses seen.
  task automatic frame(input logic [31:0] kc);
    @(negedge Clk);
    keycode = kc; frame_clk = 1'b1; pulses = 0;
    @(negedge Clk); pulses += int'(update_done);
    @(negedge Clk); pulses += int'(update_done); frame_clk = 1'b0;
    @(negedge Clk); pulses += int'(update_done);
    @(negedge Clk); pulses += int'(update_done);
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1; frame_clk = 1'b0; keycode = 32'h0;
    cyc(2); Reset = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] tbl[6] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h52};
    logic [31:0] kc;
    Reset = 1'b1; frame_clk = 1'b0; keycode = 32'h0;
    @(negedge Clk); chk_en = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    chk("rst_x", int'(TankX), 100); chk("rst_y", int'(TankY), 100);
    chk("rst_h", int'(Heading), 0); chk("rst_mov", int'(moving), 0);
    chk("rst_done", int'(update_done), 0);

    frame(32'h0000001A);
    chk("fwd_y", int'(TankY), 97); chk("fwd_x", int'(TankX), 100);
    chk("fwd_mov", int'(moving), 1); chk("fwd_pulses", pulses, 1);

    // Rotation with cooldown.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      frame(32'h07000000);
      if (i == 1) chk("rot_f1", int'(Heading), (RS) % 8);
      if (i == 9) chk("rot_f9", int'(Heading), (2 * RS) % 8);
      if (i == 17) chk("rot_f17", int'(Heading), (3 * RS) % 8);
    end
    frame(32'h00000704);
    chk("rot_both", int'(Heading), (3 * RS) % 8);
    frame(32'h00000007);
    chk("rot_cd_clear", int'(Heading), (4 * RS) % 8);

    // Right-wall clamp and sliding.
    do_reset();
`ifdef TANK_DIAG_EN
    frame(32'h07); frame(32'h00); frame(32'h07);
`else
    frame(32'h07);
`endif
    chk("east_h", int'(Heading), 2);
    frame(32'h1A);
    chk("east_x", int'(TankX), 103);
    repeat (180) frame(32'h1A);
    chk("wall_x", int'(TankX), 631); chk("wall_mov", int'(moving), 0);
    frame(32'h04);
    frame(32'h1A);
    chk("slide_x", int'(TankX), 631); chk("slide_mov", int'(moving), 1);
`ifdef TANK_DIAG_EN
    chk("slide_y", int'(TankY), 98);
`else
    chk("slide_y", int'(TankY), 97);
`endif

    // Forward and back together.
    frame(32'h00001A16);
    chk("ws_mov", int'(moving), 0); chk("ws_pulses", pulses, 1);

    // Reset during the MOVE cycle discards the update.
    do_reset();
    @(negedge Clk); keycode = 32'h1A; frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    chk("rmove_y", int'(TankY), 100); chk("rmove_x", int'(TankX), 100);
    chk("rmove_done", int'(update_done), 0);
    Reset = 1'b0; frame_clk = 1'b0;

    // Randomized traffic, including ticks that arrive while busy.
    for (int n = 0; n < 4000; n++) begin
      @(negedge Clk);
      if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
      if ($urandom_range(0, 7) == 0) begin
        for (int s = 0; s < 4; s++) kc[s*8 +: 8] = tbl[$urandom_range(0, 5)];
        keycode = kc;
      end
      Reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge Clk); Reset = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
